// File: rtl/tc_tile_sched.sv
// tc_tile_sched: GEMM job scheduler for the tensor-core tile array.
// Walks output tiles m-major then n, requests kt operand tiles per output
// tile, tags each accepted issue through the fixed array latency and
// accumulates the returning partial tiles lane-wise.
// Optional build macro: TC_TILE_SCHED_SAT_EN (saturating lane accumulation;
// without it lanes wrap modulo 2^DW_OUT).
//
// state | meaning
// IDLE  | waiting for a job descriptor, cfg_ready high
// ISSUE | requesting operand tiles k = 0 .. kt-1 for the current output tile
// DRAIN | all K steps issued, waiting for the last tagged partial tile
// OUT   | accumulated tile presented on the result port
module tc_tile_sched #(
  parameter int TILE_M    = 4,
  parameter int TILE_N    = 4,
  parameter int DW_OUT    = 32,
  parameter int CNT_W     = 8,
  parameter int ARRAY_LAT = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_valid,
  output logic                            cfg_ready,
  input  logic [CNT_W-1:0]                cfg_mt,
  input  logic [CNT_W-1:0]                cfg_nt,
  input  logic [CNT_W-1:0]                cfg_kt,
  output logic                            op_req,
  output logic [CNT_W-1:0]                op_m_idx,
  output logic [CNT_W-1:0]                op_n_idx,
  output logic [CNT_W-1:0]                op_k_idx,
  input  logic                            op_gnt,
  output logic                            arr_valid,
  input  logic [TILE_M*TILE_N*DW_OUT-1:0] arr_out,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [TILE_M*TILE_N*DW_OUT-1:0] res_data,
  output logic [CNT_W-1:0]                res_m_idx,
  output logic [CNT_W-1:0]                res_n_idx,
  output logic                            busy,
  output logic                            done
);
  localparam int LANES = TILE_M * TILE_N;
  localparam int TW    = LANES * DW_OUT;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       mt_q, mt_d, nt_q, nt_d, kt_q, kt_d;
  logic [CNT_W-1:0]       m_q, m_d, n_q, n_d, k_q, k_d;
  logic                   op_req_q, op_req_d;
  logic                   res_valid_q, res_valid_d;
  logic                   busy_q, busy_d;
  logic                   cfg_ready_q, cfg_ready_d;
  logic                   done_q, done_d;
  logic [ARRAY_LAT-1:0]   tv_q, tv_d, tf_q, tf_d, tl_q, tl_d;
  logic [TW-1:0]          acc_q, acc_d;
  logic                   issue_fire;
  logic                   tag_valid, tag_first, tag_last;
  logic                   last_tile;
`ifdef TC_TILE_SCHED_SAT_EN
  logic [DW_OUT:0]        lane_sum;
`endif

  assign issue_fire = op_req_q & op_gnt;
  assign tag_valid  = tv_q[ARRAY_LAT-1];
  assign tag_first  = tf_q[ARRAY_LAT-1];
  assign tag_last   = tl_q[ARRAY_LAT-1];
  assign last_tile  = (m_q == mt_q - CNT_W'(1)) && (n_q == nt_q - CNT_W'(1));

  assign arr_valid = issue_fire;
  assign cfg_ready = cfg_ready_q;
  assign op_req    = op_req_q;
  assign op_m_idx  = m_q;
  assign op_n_idx  = n_q;
  assign op_k_idx  = k_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_m_idx = m_q;
  assign res_n_idx = n_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Tag pipe: one {valid, first, last} entry per accepted issue, ARRAY_LAT deep
  always_comb begin
    tv_d    = '0;
    tf_d    = '0;
    tl_d    = '0;
    tv_d[0] = issue_fire;
    tf_d[0] = issue_fire && (k_q == '0);
    tl_d[0] = issue_fire && (k_q == kt_q - CNT_W'(1));
    for (int i = 1; i < ARRAY_LAT; i++) begin
      tv_d[i] = tv_q[i-1];
      tf_d[i] = tf_q[i-1];
      tl_d[i] = tl_q[i-1];
    end
  end

  // Lane-wise accumulation of the partial tile selected by the tag pipe output
  always_comb begin
    acc_d = acc_q;
`ifdef TC_TILE_SCHED_SAT_EN
    lane_sum = '0;
`endif
    if (tag_valid) begin
      for (int i = 0; i < LANES; i++) begin
        if (tag_first) begin
          acc_d[i*DW_OUT +: DW_OUT] = arr_out[i*DW_OUT +: DW_OUT];
        end else begin
`ifdef TC_TILE_SCHED_SAT_EN
          lane_sum = {acc_q[i*DW_OUT+DW_OUT-1], acc_q[i*DW_OUT +: DW_OUT]}
                   + {arr_out[i*DW_OUT+DW_OUT-1], arr_out[i*DW_OUT +: DW_OUT]};
          if (lane_sum[DW_OUT] != lane_sum[DW_OUT-1]) begin
            acc_d[i*DW_OUT +: DW_OUT] = lane_sum[DW_OUT] ? {1'b1, {(DW_OUT-1){1'b0}}}
                                                         : {1'b0, {(DW_OUT-1){1'b1}}};
          end else begin
            acc_d[i*DW_OUT +: DW_OUT] = lane_sum[DW_OUT-1:0];
          end
`else
          acc_d[i*DW_OUT +: DW_OUT] = acc_q[i*DW_OUT +: DW_OUT] + arr_out[i*DW_OUT +: DW_OUT];
`endif
        end
      end
    end
  end

  // Job sequencing: next state, indices and registered handshake outputs
  always_comb begin
    state_d     = state_q;
    mt_d        = mt_q;
    nt_d        = nt_q;
    kt_d        = kt_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    op_req_d    = op_req_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    cfg_ready_d = cfg_ready_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          mt_d = cfg_mt;
          nt_d = cfg_nt;
          kt_d = cfg_kt;
          m_d  = '0;
          n_d  = '0;
          k_d  = '0;
          // An empty job completes immediately without touching the array
          if (cfg_mt == '0 || cfg_nt == '0 || cfg_kt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            op_req_d    = 1'b1;
            busy_d      = 1'b1;
            cfg_ready_d = 1'b0;
          end
        end
      end
      S_ISSUE: begin
        if (issue_fire) begin
          k_d = k_q + CNT_W'(1);
          if (k_q == kt_q - CNT_W'(1)) begin
            op_req_d = 1'b0;
            state_d  = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (tag_valid && tag_last) begin
          state_d     = S_OUT;
          res_valid_d = 1'b1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          k_d         = '0;
          if (last_tile) begin
            state_d     = S_IDLE;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            cfg_ready_d = 1'b1;
          end else begin
            if (n_q == nt_q - CNT_W'(1)) begin
              n_d = '0;
              m_d = m_q + CNT_W'(1);
            end else begin
              n_d = n_q + CNT_W'(1);
            end
            state_d  = S_ISSUE;
            op_req_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, tag pipe and accumulator registers; reset aborts any job in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mt_q        <= '0;
      nt_q        <= '0;
      kt_q        <= '0;
      m_q         <= '0;
      n_q         <= '0;
      k_q         <= '0;
      op_req_q    <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      done_q      <= 1'b0;
      tv_q        <= '0;
      tf_q        <= '0;
      tl_q        <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      mt_q        <= mt_d;
      nt_q        <= nt_d;
      kt_q        <= kt_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      op_req_q    <= op_req_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
      done_q      <= done_d;
      tv_q        <= tv_d;
      tf_q        <= tf_d;
      tl_q        <= tl_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_tc_tile_sched.sv
// Testbench for tc_tile_sched: randomized grant/ready/data traffic checked
// against a job-level reference (tile order, K sums, event cycles).
module tb_tc_tile_sched;
  localparam int TILE_M    = 4;
  localparam int TILE_N    = 4;
  localparam int DW_OUT    = 32;
  localparam int CNT_W     = 8;
  localparam int ARRAY_LAT = 2;
  localparam int LANES     = TILE_M * TILE_N;
  localparam int TW        = LANES * DW_OUT;
  localparam longint SMAX  = 2147483647;
  localparam longint SMIN  = -SMAX - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_mt = '0, cfg_nt = '0, cfg_kt = '0;
  logic             op_req;
  logic [CNT_W-1:0] op_m_idx, op_n_idx, op_k_idx;
  logic             op_gnt = 1'b0;
  logic             arr_valid;
  logic [TW-1:0]    arr_out = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [TW-1:0]    res_data;
  logic [CNT_W-1:0] res_m_idx, res_n_idx;
  logic             busy, done;

  tc_tile_sched #(
    .TILE_M(TILE_M), .TILE_N(TILE_N), .DW_OUT(DW_OUT), .CNT_W(CNT_W), .ARRAY_LAT(ARRAY_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mt(cfg_mt), .cfg_nt(cfg_nt), .cfg_kt(cfg_kt),
    .op_req(op_req), .op_m_idx(op_m_idx), .op_n_idx(op_n_idx), .op_k_idx(op_k_idx),
    .op_gnt(op_gnt), .arr_valid(arr_valid), .arr_out(arr_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_m_idx(res_m_idx), .res_n_idx(res_n_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Operand data per (m, n, k) step of the current job
  logic [TW-1:0] tdata [3][3][4];

  typedef struct {
    int            due;
    logic [TW-1:0] d;
  } pend_t;
  pend_t pq[$];

  int gnt_pct, rdy_pct, rdy_hold, stall_k, stall_len;

  task automatic chk(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) r[l*DW_OUT +: DW_OUT] = $urandom;
    return r;
  endfunction

  // Reference: K-step lane sums, signed, wrapping or saturating after each add
  function automatic logic [TW-1:0] exp_tile(input int m, input int n, input int kt);
    logic [TW-1:0] r;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      longint s;
      s = 0;
      for (int k = 0; k < kt; k++) begin
        logic [31:0] w;
        longint      v;
        w = tdata[m][n][k][l*DW_OUT +: DW_OUT];
        v = longint'($signed(w));
        if (k == 0) s = v;
        else begin
          s = s + v;
`ifdef TC_TILE_SCHED_SAT_EN
          if (s > SMAX) s = SMAX;
          else if (s < SMIN) s = SMIN;
`else
          s = longint'($signed(s[31:0]));
`endif
        end
      end
      r[l*DW_OUT +: DW_OUT] = s[31:0];
    end
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, TW'(cfg_ready), TW'(1));
    chk({tag, "_busy"}, TW'(busy), TW'(0));
    chk({tag, "_op_req"}, TW'(op_req), TW'(0));
    chk({tag, "_arr_valid"}, TW'(arr_valid), TW'(0));
    chk({tag, "_res_valid"}, TW'(res_valid), TW'(0));
    chk({tag, "_done"}, TW'(done), TW'(0));
    chk({tag, "_idx"}, TW'({op_m_idx, op_n_idx, op_k_idx, res_m_idx, res_n_idx}), TW'(0));
    chk({tag, "_res_data"}, res_data, TW'(0));
  endtask

  // Runs one job; cycle 0 is the acceptance cycle of the descriptor
  task automatic run_job(input int mt, input int nt, input int kt,
                         output int first_res_c, output int done_c,
                         output int done_pulses, output logic [TW-1:0] last_res);
    int em, en, ek, c, res_due, exp_done_c, stall_left, hold_cnt;
    bit zero, exp_op_req, nxt_op_req, exp_rv, exp_busy, fin;
    pend_t p;
    zero        = (mt == 0) || (nt == 0) || (kt == 0);
    first_res_c = -1;
    done_c      = -1;
    done_pulses = 0;
    last_res    = '0;
    em = 0; en = 0; ek = 0;
    res_due     = -1;
    exp_done_c  = zero ? 1 : (1 << 30);
    stall_left  = stall_len;
    hold_cnt    = 0;
    nxt_op_req  = !zero;
    exp_rv      = 1'b0;
    fin         = 1'b0;
    pq.delete();
    @(negedge clk);
    chk("cfg_ready_idle", TW'(cfg_ready), TW'(1));
    cfg_valid = 1'b1;
    cfg_mt = CNT_W'(mt);
    cfg_nt = CNT_W'(nt);
    cfg_kt = CNT_W'(kt);
    op_gnt = 1'b0;
    res_ready = 1'b0;
    arr_out = rand_tile();
    c = 0;
    while (!fin && c < 3000) begin
      @(negedge clk);
      c++;
      exp_op_req = nxt_op_req;
      if (c == res_due) exp_rv = 1'b1;
      exp_busy = !zero && (c < exp_done_c);
      chk("op_req", TW'(op_req), TW'(exp_op_req));
      chk("res_valid", TW'(res_valid), TW'(exp_rv));
      chk("done", TW'(done), TW'(c == exp_done_c));
      chk("busy", TW'(busy), TW'(exp_busy));
      chk("cfg_ready", TW'(cfg_ready), TW'(!exp_busy));
      if (done) begin
        done_pulses++;
        if (done_c < 0) done_c = c;
      end
      // descriptors offered while busy must be ignored
      cfg_valid = exp_busy ? 1'($urandom_range(1)) : 1'b0;
      cfg_mt = CNT_W'($urandom);
      cfg_nt = CNT_W'($urandom);
      cfg_kt = CNT_W'($urandom);
      if (op_req && ek == stall_k && stall_left > 0) begin
        op_gnt = 1'b0;
        stall_left--;
      end else begin
        op_gnt = ($urandom_range(99) < gnt_pct);
      end
      if (res_valid && hold_cnt < rdy_hold) begin
        res_ready = 1'b0;
        hold_cnt++;
      end else begin
        res_ready = ($urandom_range(99) < rdy_pct);
      end
      if (pq.size() > 0 && pq[0].due == c) begin
        p = pq.pop_front();
        arr_out = p.d;
      end else begin
        arr_out = rand_tile();
      end
      #1;
      chk("arr_valid", TW'(arr_valid), TW'(op_req & op_gnt));
      if (op_req) begin
        chk("op_m_idx", TW'(op_m_idx), TW'(em));
        chk("op_n_idx", TW'(op_n_idx), TW'(en));
        chk("op_k_idx", TW'(op_k_idx), TW'(ek));
      end
      if (op_req && op_gnt && exp_op_req) begin
        p.due = c + ARRAY_LAT;
        p.d   = tdata[em][en][ek];
        pq.push_back(p);
        if (ek == kt - 1) begin
          nxt_op_req = 1'b0;
          res_due    = c + ARRAY_LAT + 1;
          ek         = 0;
        end else begin
          ek++;
        end
      end
      if (res_valid && exp_rv) begin
        chk("res_data", res_data, exp_tile(em, en, kt));
        chk("res_m_idx", TW'(res_m_idx), TW'(em));
        chk("res_n_idx", TW'(res_n_idx), TW'(en));
        if (first_res_c < 0) first_res_c = c;
        if (res_ready) begin
          last_res = res_data;
          exp_rv   = 1'b0;
          res_due  = -1;
          hold_cnt = 0;
          if (em == mt - 1 && en == nt - 1) begin
            exp_done_c = c + 1;
          end else begin
            if (en == nt - 1) begin
              en = 0;
              em++;
            end else begin
              en++;
            end
            nxt_op_req = 1'b1;
          end
        end
      end
      if (c == exp_done_c) fin = 1'b1;
    end
    chk("job_finished", TW'(fin), TW'(1));
    cfg_valid = 1'b0;
  endtask

  initial begin
    int fr, dc, dp;
    logic [TW-1:0] lr;
    logic [TW-1:0] t;
    gnt_pct = 100; rdy_pct = 100; rdy_hold = 0; stall_k = 0; stall_len = 0;

    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // single tile, single K step
    tdata[0][0][0] = {LANES{32'd5}};
    run_job(1, 1, 1, fr, dc, dp, lr);
    chk("t1_res_cycle", TW'(fr), TW'(4));
    chk("t1_done_cycle", TW'(dc), TW'(5));
    chk("t1_lanes", lr, {LANES{32'd5}});

    // K accumulation with a two-cycle grant stall at k=1
    tdata[0][0][0] = {LANES{32'd2}};
    tdata[0][0][1] = {LANES{32'd3}};
    tdata[0][0][2] = {LANES{32'd4}};
    stall_k = 1; stall_len = 2;
    run_job(1, 1, 3, fr, dc, dp, lr);
    chk("t2_res_cycle", TW'(fr), TW'(3 + 1 + ARRAY_LAT + 2));
    chk("t2_lanes", lr, {LANES{32'd9}});
    stall_len = 0;

    // traversal order with result backpressure
    for (int m = 0; m < 2; m++)
      for (int n = 0; n < 2; n++)
        for (int k = 0; k < 2; k++) tdata[m][n][k] = rand_tile();
    rdy_hold = 3;
    run_job(2, 2, 2, fr, dc, dp, lr);
    chk("t3_done_pulses", TW'(dp), TW'(1));
    rdy_hold = 0;

    // lane overflow
    t = rand_tile();
    t[31:0] = 32'h7FFF_FFFF;
    tdata[0][0][0] = t;
    t = rand_tile();
    t[31:0] = 32'h0000_0001;
    tdata[0][0][1] = t;
    run_job(1, 1, 2, fr, dc, dp, lr);
`ifdef TC_TILE_SCHED_SAT_EN
    chk("t4_ovf_lane0", TW'(lr[31:0]), TW'(32'h7FFF_FFFF));
`else
    chk("t4_ovf_lane0", TW'(lr[31:0]), TW'(32'h8000_0000));
`endif

    // reset while draining, garbage afterwards, then a clean job
    @(negedge clk);
    cfg_valid = 1'b1; cfg_mt = 8'd1; cfg_nt = 8'd1; cfg_kt = 8'd3;
    op_gnt = 1'b1; res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      arr_out = rand_tile();
    end
    chk("t5_drain_busy", TW'(busy), TW'(1));
    chk("t5_drain_op_req", TW'(op_req), TW'(0));
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      arr_out = rand_tile();
    end
    check_reset_vals("t5_after_reset");
    tdata[0][0][0] = {LANES{32'd7}};
    run_job(1, 1, 1, fr, dc, dp, lr);
    chk("t5_new_lanes", lr, {LANES{32'd7}});

    // zero-count jobs
    run_job(1, 1, 0, fr, dc, dp, lr);
    chk("t6_done_cycle", TW'(dc), TW'(1));
    chk("t6_no_result", TW'(fr < 0), TW'(1));
    run_job(0, 2, 3, fr, dc, dp, lr);
    chk("t6b_done_cycle", TW'(dc), TW'(1));

    // randomized jobs
    gnt_pct = 60; rdy_pct = 60;
    for (int j = 0; j < 8; j++) begin
      int mt, nt, kt;
      mt = $urandom_range(3, 1);
      nt = $urandom_range(3, 1);
      kt = $urandom_range(4, 1);
      rdy_hold = $urandom_range(2);
      for (int m = 0; m < 3; m++)
        for (int n = 0; n < 3; n++)
          for (int k = 0; k < 4; k++) tdata[m][n][k] = rand_tile();
      run_job(mt, nt, kt, fr, dc, dp, lr);
      chk("rand_done_pulses", TW'(dp), TW'(1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
